// File: rtl/csr_queue_writer.sv
// Write side of the CSR instruction queue: accepts dispatch writes, exposes the entry
// array flat, publishes a Gray write pointer and synchronizes the reader's Gray pointer.
module csr_queue_writer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WIDTH       = 113,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned PW         = AW + 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_Valid_1,
  output logic                   o_Ready_1,
  input  logic [WIDTH-1:0]       i_Instruction_113,
  output logic [DEPTH*WIDTH-1:0] o_InstructionToCsrIssue_1808,
  output logic [PW-1:0]          o_CsrGray_5,
  input  logic [PW-1:0]          i_CsrReadGray_5,
  output logic                   o_CsrFull_1,
  output logic [PW-1:0]          o_CsrCount_5
);

  // Handshake: a write happens on a rising clk edge where i_Valid_1 && o_Ready_1;
  // o_Ready_1 depends only on registers, never on i_Valid_1.

  logic [PW-1:0]                  wr_bin_q, wr_bin_d;
  logic [PW-1:0]                  wr_gray_q, wr_gray_d;
  logic [PW-1:0]                  pub_gray_q, pub_gray_d;
  logic [SYNC_STAGES-1:0][PW-1:0] rd_sync_q, rd_sync_d;
  logic [DEPTH-1:0][WIDTH-1:0]    mem_q, mem_d;
  logic                           rstn_q, rstn_d;

  logic [PW-1:0] rd_gray;
  logic [PW-1:0] rd_bin;
  logic          full;
  logic          wr_en;

  assign rd_gray = rd_sync_q[SYNC_STAGES-1];

  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < PW; i++) begin
      rd_bin[i] = ^(rd_gray >> i);
    end
  end

  // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
  assign full  = (wr_gray_q == {~rd_gray[PW-1:PW-2], rd_gray[PW-3:0]});
  assign wr_en = i_Valid_1 && !full && rstn_q;

  always_comb begin
    wr_bin_d  = wr_bin_q;
    wr_gray_d = wr_gray_q;
    mem_d     = mem_q;
    if (wr_en) begin
      mem_d[wr_bin_q[AW-1:0]] = i_Instruction_113;
      wr_bin_d                = wr_bin_q + PW'(1);
      wr_gray_d               = (wr_bin_d >> 1) ^ wr_bin_d;
    end
    // Publishing one cycle late keeps entry data stable before the reader sees it.
    pub_gray_d = wr_gray_q;
    rd_sync_d  = {rd_sync_q[SYNC_STAGES-2:0], i_CsrReadGray_5};
    rstn_d     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      pub_gray_q <= '0;
      rd_sync_q  <= '0;
      mem_q      <= '0;
      rstn_q     <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      pub_gray_q <= pub_gray_d;
      rd_sync_q  <= rd_sync_d;
      mem_q      <= mem_d;
      rstn_q     <= rstn_d;
    end
  end

  assign o_Ready_1                    = !full && rstn_q;
  assign o_CsrFull_1                  = full;
  assign o_CsrCount_5                 = wr_bin_q - rd_bin;
  assign o_CsrGray_5                  = pub_gray_q;
  assign o_InstructionToCsrIssue_1808 = mem_q;

endmodule

// File: tb/tb_csr_queue_writer.sv
// Directed bench for csr_queue_writer: reset, single write, fill, drain, wrap and
// mid-operation reset, each scenario checking its own expected values.
module tb_csr_queue_writer;

  localparam int DEPTH = 16;
  localparam int WIDTH = 113;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   valid;
  logic                   ready;
  logic [WIDTH-1:0]       instr;
  logic [DEPTH*WIDTH-1:0] arr;
  logic [4:0]             gray_out;
  logic [4:0]             rd_gray_in;
  logic                   full;
  logic [4:0]             count;

  int tests_run    = 0;
  int tests_failed = 0;

  csr_queue_writer dut (
    .clk                          (clk),
    .rstn                         (rstn),
    .i_Valid_1                    (valid),
    .o_Ready_1                    (ready),
    .i_Instruction_113            (instr),
    .o_InstructionToCsrIssue_1808 (arr),
    .o_CsrGray_5                  (gray_out),
    .i_CsrReadGray_5              (rd_gray_in),
    .o_CsrFull_1                  (full),
    .o_CsrCount_5                 (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] entry(input int k);
    return arr[k*WIDTH +: WIDTH];
  endfunction

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] fill_val(input int i);
    return {81'h1_5A5A_0000_0000_0000_0000, 32'(32'hF000 + i)};
  endfunction

  task automatic do_reset();
    rstn       = 1'b0;
    valid      = 1'b0;
    rd_gray_in = 5'd0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn       = 1'b0;
    valid      = 1'b1;
    instr      = {WIDTH{1'b1}};
    rd_gray_in = 5'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if ({ready, full, count, gray_out} !== 12'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs cyc%0d: ready=%b full=%b count=%0d gray=%b, all must be 0",
                 c, ready, full, count, gray_out);
      end
      tests_run++;
      if (arr !== '0) begin
        tests_failed++;
        $display("FAIL reset_array cyc%0d: array nonzero=%b, required 0", c, |arr);
      end
    end
    rstn  = 1'b1;
    valid = 1'b0;
    tests_run++;
    if (ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_first_cycle: ready=%b, required 0", ready);
    end
    tick();
    tests_run++;
    if (ready !== 1'b1 || count !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_release_second_cycle: ready=%b count=%0d, required 1 and 0", ready, count);
    end
  endtask

  task automatic test_single_write();
    valid = 1'b1;
    instr = 113'h1_ABCD;
    tick();
    valid = 1'b0;
    tests_run++;
    if (entry(0) !== 113'h1_ABCD) begin
      tests_failed++;
      $display("FAIL single_entry0: got %h, required %h", entry(0), 113'h1_ABCD);
    end
    tests_run++;
    if (count !== 5'd1) begin
      tests_failed++;
      $display("FAIL single_count: got %0d, required 1", count);
    end
    tests_run++;
    if (gray_out !== 5'b00000) begin
      tests_failed++;
      $display("FAIL single_gray_lag: got %b, required 00000", gray_out);
    end
    tick();
    tests_run++;
    if (gray_out !== 5'b00001) begin
      tests_failed++;
      $display("FAIL single_gray_pub: got %b, required 00001", gray_out);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL fill_ready_%0d: got %b, required 1", i, ready);
      end
      valid = 1'b1;
      instr = fill_val(i);
      tick();
    end
    tests_run++;
    if (full !== 1'b1 || ready !== 1'b0 || count !== 5'd16) begin
      tests_failed++;
      $display("FAIL fill_full: full=%b ready=%b count=%0d, required 1 0 16", full, ready, count);
    end
    instr = fill_val(16);
    tick();
    tests_run++;
    if (gray_out !== 5'b11000) begin
      tests_failed++;
      $display("FAIL fill_gray: got %b, required 11000", gray_out);
    end
    tests_run++;
    if (count !== 5'd16 || full !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_held_count: count=%0d full=%b, required 16 1", count, full);
    end
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (entry(k) !== fill_val(k)) begin
        tests_failed++;
        $display("FAIL fill_entry_%0d: got %h, required %h", k, entry(k), fill_val(k));
      end
    end
  endtask

  task automatic test_drain_one();
    rd_gray_in = 5'b00001;
    tick();
    tests_run++;
    if (ready !== 1'b0 || count !== 5'd16) begin
      tests_failed++;
      $display("FAIL drain_sync_lag: ready=%b count=%0d, required 0 16", ready, count);
    end
    tick();
    tests_run++;
    if (ready !== 1'b1 || count !== 5'd15 || full !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_seen: ready=%b count=%0d full=%b, required 1 15 0", ready, count, full);
    end
    tick();
    valid = 1'b0;
    tests_run++;
    if (entry(0) !== fill_val(16)) begin
      tests_failed++;
      $display("FAIL drain_next_entry0: got %h, required %h", entry(0), fill_val(16));
    end
    tests_run++;
    if (count !== 5'd16 || full !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_refull: count=%0d full=%b, required 16 1", count, full);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] prev_gray;
    logic [4:0] diff;
    bit         seen_wrap;
    do_reset();
    prev_gray = 5'd0;
    seen_wrap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rd_gray_in = (i >= 3) ? to_gray(5'(i - 3)) : 5'd0;
      valid      = 1'b1;
      instr      = fill_val(100 + i);
      tests_run++;
      if (ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL wrap_ready_%0d: got %b, required 1", i, ready);
      end
      tick();
      tests_run++;
      if (gray_out !== to_gray(5'(i))) begin
        tests_failed++;
        $display("FAIL wrap_gray_%0d: got %b, required %b", i, gray_out, to_gray(5'(i)));
      end
      if (i > 0) begin
        diff = gray_out ^ prev_gray;
        tests_run++;
        if ($countones(diff) != 1) begin
          tests_failed++;
          $display("FAIL wrap_gray_step_%0d: %b -> %b, required one bit change", i, prev_gray, gray_out);
        end
        if (prev_gray == 5'b10000 && gray_out == 5'b00000) seen_wrap = 1'b1;
      end
      prev_gray = gray_out;
    end
    valid = 1'b0;
    tests_run++;
    if (!seen_wrap) begin
      tests_failed++;
      $display("FAIL wrap_gray_31_to_0: transition 10000 -> 00000 seen=%b, required 1", seen_wrap);
    end
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (entry(k) !== fill_val(100 + ((k < 8) ? 32 + k : 16 + k))) begin
        tests_failed++;
        $display("FAIL wrap_entry_%0d: got %h, required %h", k, entry(k),
                 fill_val(100 + ((k < 8) ? 32 + k : 16 + k)));
      end
    end
    tick();
    tick();
    tests_run++;
    if (count !== 5'd4) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d, required 4", count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      valid = 1'b1;
      instr = fill_val(200 + i);
      tick();
    end
    valid = 1'b0;
    tests_run++;
    if (count !== 5'd9) begin
      tests_failed++;
      $display("FAIL mid_count_before: got %0d, required 9", count);
    end
    rstn  = 1'b0;
    valid = 1'b1;
    instr = fill_val(300);
    tick();
    tests_run++;
    if ({ready, full, count, gray_out} !== 12'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: ready=%b full=%b count=%0d gray=%b, required all 0",
               ready, full, count, gray_out);
    end
    tests_run++;
    if (arr !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_array: nonzero=%b, required 0", |arr);
    end
    rstn  = 1'b1;
    valid = 1'b0;
    tick();
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_ready_after: got %b, required 1", ready);
    end
    valid = 1'b1;
    instr = fill_val(400);
    tick();
    valid = 1'b0;
    tests_run++;
    if (entry(0) !== fill_val(400) || entry(1) !== '0) begin
      tests_failed++;
      $display("FAIL mid_next_entry0: e0=%h e1=%h, required %h and 0", entry(0), entry(1), fill_val(400));
    end
    tests_run++;
    if (count !== 5'd1) begin
      tests_failed++;
      $display("FAIL mid_count_after: got %0d, required 1", count);
    end
  endtask

  initial begin
    rstn       = 1'b0;
    valid      = 1'b0;
    instr      = '0;
    rd_gray_in = '0;
    test_reset();
    test_single_write();
    test_fill();
    test_drain_one();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/csr_queue_writer.md
# csr_queue_writer

Write end of the 16-entry CSR instruction queue drained by the CSR issue stage. The block accepts CSR instructions from dispatch over a valid/ready handshake and stores them in a flat 16 × 113-bit register array. The issue stage reads that array directly. The block publishes a 5-bit Gray write pointer and takes back the issue stage's 5-bit Gray read pointer, which it synchronizes to compute full status and occupancy.

## Interface
Parameters:
- DEPTH, 16, queue entries; power of two; pointer width is log2(DEPTH)+1 = 5
- WIDTH, 113, bits per CSR instruction entry
- SYNC_STAGES, 2, flops in the read-pointer synchronizer (minimum 2)

Ports:
- clk  in  1  single clock for the whole block
- rstn  in  1  reset; synchronous, active-low
- i_Valid_1  in  1  dispatch offers an instruction
- o_Ready_1  out  1  queue can accept; a write occurs on a rising clk edge with i_Valid_1 && o_Ready_1
- i_Instruction_113  in  WIDTH  instruction payload; sampled only on a write
- o_InstructionToCsrIssue_1808  out  DEPTH*WIDTH  packed array; entry k occupies bits [113k+112 : 113k]
- o_CsrGray_5  out  5  published Gray write pointer, registered
- i_CsrReadGray_5  in  5  issue-stage Gray read pointer; asynchronous to clk
- o_CsrFull_1  out  1  queue full, as seen through the synchronized read pointer
- o_CsrCount_5  out  5  occupancy 0..16, conservative (never under-reports)

## Operation
- State:
  - r_WrBin_5: binary write pointer.
  - r_WrGray_5: Gray form of r_WrBin_5.
  - r_PubGray_5: drives o_CsrGray_5.
  - r_RdSync: SYNC_STAGES × 5 synchronizer chain.
  - mem: DEPTH × WIDTH entry array.
- Write. On a write:
  - mem[r_WrBin_5[3:0]] <= i_Instruction_113.
  - r_WrBin_5 <= r_WrBin_5 + 1 (mod 32).
  - r_WrGray_5 <= (next >> 1) ^ next.
- Publish. r_PubGray_5 <= r_WrGray_5 every cycle, so the published pointer lags the internal pointer by one cycle. This guarantees the entry data is stable at least one full cycle before the reader can see that entry.
- Synchronizer. i_CsrReadGray_5 passes through SYNC_STAGES flops. The last stage is the synchronized read Gray pointer, RdG; RdB is its binary conversion (prefix XOR from MSB).
- Full. o_CsrFull_1 = (r_WrGray_5 == {~RdG[4:3], RdG[2:0]}).
- Ready. o_Ready_1 = !o_CsrFull_1 && rstn_q, where rstn_q is a registered copy of rstn.
  - Ready is a function of registers only; it never depends on i_Valid_1.
- Count. o_CsrCount_5 = r_WrBin_5 − RdB (mod 32), giving 0..16.
  - Count equal to 16 if and only if o_CsrFull_1 is high.
- Empty detection belongs to the issue stage (compares o_CsrGray_5 against its own pointer); this block has no empty output.
- Write while full: blocked by ready; no entry is ever overwritten while unread.
- Wrap-around: entry index r_WrBin_5[3:0] wraps 15 → 0. The MSB toggles each 16 writes; the Gray sequence stays single-bit-change across the 31 → 0 wrap.
- Reset (rstn low at a clk edge):
  - All pointers, synchronizer flops, mem, and rstn_q are cleared to 0.
  - The rstn_q clear forces o_Ready_1 low during reset and for the first cycle after release.
  - Reset mid-operation discards all entries. The issue stage must be reset in the same window.

## Timing
- Reset values:
  - o_Ready_1 = 0
  - o_CsrFull_1 = 0
  - o_CsrCount_5 = 0
  - o_CsrGray_5 = 5'b00000
  - o_InstructionToCsrIssue_1808 = 0
- First rising edge with rstn high: o_Ready_1 = 1 from the following cycle.
- Write at edge N:
  - Entry data visible at the output after edge N.
  - o_CsrCount_5 incremented after edge N.
  - o_CsrGray_5 updated after edge N+1.
- Read-pointer change, stable before edge M: reflected in full/count/ready after edge M+SYNC_STAGES−1. With the default SYNC_STAGES = 2, that is 2 cycles of latency.
- Simultaneous write and read-pointer change at the same edge: both apply. The count reflects the write immediately and the read after the synchronizer latency.
- Throughput: one write per cycle while not full.

## Test plan
- Reset: hold rstn low 3 cycles with i_Valid_1 = 1.
  - No write occurs; all outputs stay 0.
  - o_Ready_1 = 1 on the second cycle after release.
- Single write: write 113'h1_ABCD.
  - Bits [112:0] of the array = 113'h1_ABCD; o_CsrCount_5 = 1.
  - One cycle later, o_CsrGray_5 = 5'b00001.
- Fill: 16 back-to-back writes with read pointer 0.
  - After the 16th write: o_CsrFull_1 = 1, o_Ready_1 = 0, o_CsrCount_5 = 16, o_CsrGray_5 = 5'b11000.
  - A 17th valid is held and entry 0 is unchanged.
- Drain by one: from full, set i_CsrReadGray_5 = 5'b00001.
  - Two cycles later: o_Ready_1 = 1, o_CsrCount_5 = 15.
  - The next write lands in entry 0.
- Wrap: 40 writes with the read pointer following 3 writes behind.
  - o_CsrGray_5 changes exactly one bit per step and passes 31 → 0 (5'b10000 → 5'b00000).
  - Entries 0..7 hold writes 32..39.
- Reset mid-operation: with 9 entries queued, pull rstn low for 1 cycle.
  - Count, pointers, and array return to 0.
  - The next accepted write lands in entry 0.
